// File: rtl/matrix_row_mac32_if.sv
// Row-MAC bus: A row, B column, row/column indices and the registered C row.
// master drives operands and indices; slave (the MAC) returns Answer.
interface matrix_row_mac32_if;
  logic [1023:0] A_wire;
  logic [1023:0] B_wire;
  logic [4:0]    index_A;
  logic [4:0]    index_B;
  logic [1023:0] Answer;

  modport master (
    output A_wire,
    output B_wire,
    output index_A,
    output index_B,
    input  Answer
  );

  modport slave (
    input  A_wire,
    input  B_wire,
    input  index_A,
    input  index_B,
    output Answer
  );
endinterface

// File: rtl/matrix_row_mac32.sv
// One row of a 32x32 signed matrix product, one dot product per clock.
// Ports: clk, reset (async active-low), bus (slave: A_wire, B_wire,
// index_A, index_B in; Answer out). Macro MM32_SATURATE_EN clamps
// the exact sum to signed 32 bits instead of wrapping.
module matrix_row_mac32 (
  input logic               clk,
  input logic               reset,
  matrix_row_mac32_if.slave bus
);

`ifdef MM32_SATURATE_EN
  logic signed [63:0] prod;
  logic signed [68:0] acc;
`else
  // Wrapped result only depends on the low 32 bits of every product.
  logic [31:0] prod;
  logic [31:0] acc;
`endif

  logic [31:0]   result;
  logic [1023:0] ans_q;
  logic [4:0]    row_q;
  logic          new_row;

  always_comb begin
    prod = '0;
    acc  = '0;
    for (int k = 0; k < 32; k++) begin
`ifdef MM32_SATURATE_EN
      prod = $signed(bus.A_wire[32*k +: 32])
           * $signed(bus.B_wire[32*k +: 32]);
`else
      prod = bus.A_wire[32*k +: 32]
           * bus.B_wire[32*k +: 32];
`endif
      acc = acc + prod;
    end
  end

  always_comb begin
`ifdef MM32_SATURATE_EN
    // In range iff bits 68..31 are all copies of the sign.
    if ((&acc[68:31]) || !(|acc[68:31]))
      result = acc[31:0];
    else if (acc[68])
      result = 32'h8000_0000;
    else
      result = 32'h7fff_ffff;
`else
    result = acc;
`endif
  end

  assign new_row = (bus.index_A != row_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ans_q <= '0;
      row_q <= '0;
    end else begin
      for (int j = 0; j < 32; j++) begin
        if (5'(j) == bus.index_B)
          ans_q[32*j +: 32] <= result;
        else if (new_row)
          ans_q[32*j +: 32] <= '0;
      end
      row_q <= bus.index_A;
    end
  end

  assign bus.Answer = ans_q;

endmodule

// File: tb/tb_matrix_row_mac32.sv
// Directed bench for matrix_row_mac32: table of uniform-element vectors
// checked against a slot model, plus reset, sweep and row-change sequences.
module tb_matrix_row_mac32;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  matrix_row_mac32_if bus ();

  matrix_row_mac32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  ia;
    logic [4:0]  ib;
    logic [31:0] exp_wrap;
    logic [31:0] exp_sat;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] model [32];
  logic [4:0]  row_m;

  function automatic logic [1023:0] model_row();
    logic [1023:0] r;
    for (int j = 0; j < 32; j++) r[32*j +: 32] = model[j];
    return r;
  endfunction

  task automatic check(input string nm,
                       input logic [1023:0] got,
                       input logic [1023:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic check32(input string nm,
                         input logic [31:0] got,
                         input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic model_write(input logic [4:0] ia,
                             input logic [4:0] ib,
                             input logic [31:0] v);
    if (ia != row_m)
      for (int j = 0; j < 32; j++) model[j] = '0;
    row_m     = ia;
    model[ib] = v;
  endtask

  // Drive at negedge, write on posedge, sample 1 time unit later.
  task automatic write_uni(input logic [31:0] a,
                           input logic [31:0] b,
                           input logic [4:0]  ia,
                           input logic [4:0]  ib);
    @(negedge clk);
    bus.A_wire  = {32{a}};
    bus.B_wire  = {32{b}};
    bus.index_A = ia;
    bus.index_B = ib;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    row_m = '0;
    for (int j = 0; j < 32; j++) model[j] = '0;

    vecs[0] = '{32'd1, 32'd1, 5'd0, 5'd0,
                32'd32, 32'd32};
    vecs[1] = '{32'h7fff_ffff, 32'h7fff_ffff, 5'd0, 5'd1,
                32'h0000_0020, 32'h7fff_ffff};
    vecs[2] = '{32'hffff_fffd, 32'd7, 5'd0, 5'd2,
                32'hffff_fd60, 32'hffff_fd60};
    vecs[3] = '{32'd5, 32'hffff_fffc, 5'd3, 5'd31,
                32'hffff_fd80, 32'hffff_fd80};
    vecs[4] = '{32'h8000_0000, 32'h7fff_ffff, 5'd3, 5'd7,
                32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 5'd3, 5'd8,
                32'h0000_0000, 32'h7fff_ffff};
    vecs[6] = '{32'h0001_0000, 32'h0001_0000, 5'd3, 5'd7,
                32'h0000_0000, 32'h7fff_ffff};
    vecs[7] = '{32'd100, 32'd3, 5'd4, 5'd16,
                32'd9600, 32'd9600};

    // Reset with nonzero inputs and a running clock.
    reset       = 1'b1;
    bus.A_wire  = {32{32'h1234_5678}};
    bus.B_wire  = {32{32'h0000_0003}};
    bus.index_A = 5'd9;
    bus.index_B = 5'd4;
    #2 reset = 1'b0;
    #1 check("reset_async", bus.Answer, '0);
    repeat (3) begin
      @(posedge clk);
      #1 check("reset_held", bus.Answer, '0);
    end
    @(negedge clk);
    reset = 1'b1;

    // Table: uniform-element vectors, whole row checked against model.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] e;
`ifdef MM32_SATURATE_EN
      e = vecs[i].exp_sat;
`else
      e = vecs[i].exp_wrap;
`endif
      write_uni(vecs[i].a, vecs[i].b, vecs[i].ia, vecs[i].ib);
      model_write(vecs[i].ia, vecs[i].ib, e);
      check32($sformatf("vec%0d_slot", i),
              bus.Answer[32*vecs[i].ib +: 32], e);
      check($sformatf("vec%0d_row", i), bus.Answer, model_row());
    end

    // Row sweep: A[k]=k, B[k]=1 -> 496 in every slot.
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      for (int k = 0; k < 32; k++) begin
        bus.A_wire[32*k +: 32] = 32'(k);
        bus.B_wire[32*k +: 32] = 32'd1;
      end
      bus.index_A = 5'd0;
      bus.index_B = 5'(c);
      @(posedge clk);
      #1;
      model_write(5'd0, 5'(c), 32'd496);
      if (c == 0 || c == 31)
        check($sformatf("sweep_%0d", c), bus.Answer, model_row());
    end
    check("sweep_full", bus.Answer, {32{32'd496}});

    // Inputs changing between edges must not disturb Answer.
    @(negedge clk);
    bus.A_wire  = {32{32'hdead_beef}};
    bus.index_A = 5'd6;
    #2 check("no_comb_path", bus.Answer, {32{32'd496}});

    // New row: slot 5 = 128, everything else cleared.
    write_uni(32'd2, 32'd2, 5'd1, 5'd5);
    model_write(5'd1, 5'd5, 32'd128);
    check("new_row", bus.Answer, model_row());

    // Same row, overwrite slot 5 with a signed result.
    write_uni(32'hffff_fffd, 32'd7, 5'd1, 5'd5);
    model_write(5'd1, 5'd5, 32'hffff_fd60);
    check("overwrite", bus.Answer, model_row());

    // Async reset mid-row after 10 writes.
    for (int c = 0; c < 10; c++) begin
      write_uni(32'd1, 32'd1, 5'd2, 5'(c));
      model_write(5'd2, 5'(c), 32'd32);
    end
    check("mid_row_partial", bus.Answer, model_row());
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("mid_row_reset", bus.Answer, '0);
    for (int j = 0; j < 32; j++) model[j] = '0;
    row_m = '0;
    @(negedge clk);
    reset = 1'b1;

    // Writes resume with row 0 after reset.
    write_uni(32'd1, 32'd1, 5'd0, 5'd3);
    model_write(5'd0, 5'd3, 32'd32);
    write_uni(32'd2, 32'd3, 5'd0, 5'd4);
    model_write(5'd0, 5'd4, 32'd192);
    check("post_reset_row0", bus.Answer, model_row());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/matrix_row_mac32.md
# matrix_row_mac32

Computes one row of a 32×32 matrix product C = A × B, one element per clock. Each cycle it takes a 32-element row of A and a 32-element column of B and forms their dot product. The result is written into the output row slot selected by the column index. It is the multiply stage of the Jacobi eigenvalue/eigenvector datapath, fed by a controller that steps the row and column indices.

## Interface
- No parameters. Sizes are fixed: N = 32 elements, W = 32 bits per element.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `A_wire`  in  1024  one row of A. Element k is at bits [32k+31:32k], k = 0 at the LSB.
- `B_wire`  in  1024  one column of B, same packing as `A_wire`.
- `index_A`  in  5  row number of C currently being built.
- `index_B`  in  5  column number of C. Selects the output slot to write.
- `Answer`  out  1024  registered row of C. Slot j is at bits [32j+31:32j].

## Operation
- Elements are 32-bit signed two's complement integers.
- Dot product: S = Σ_{k=0..31} A[k]·B[k].
  - Each product is an exact 64-bit signed value.
  - The sum is exact in 69 bits.
- Default result is S[31:0], i.e. wrap-around modulo 2^32 (see Configuration).
- Internal register `row_q` (5 bits) holds the row index of the last write.
- On each rising edge:
  - If `index_A` == `row_q`: slot `index_B` of `Answer` takes the new result. All other slots hold.
  - If `index_A` != `row_q`: slot `index_B` takes the new result and all other slots clear to 0. This starts a new row. `row_q` takes `index_A`.
- A write happens every cycle; there is no enable or handshake.
- Rewriting the same `index_B` overwrites that slot.
- Inputs are sampled only at the clock edge. Changes between edges have no effect.
- Columns may be visited in any order. Skipped slots keep their prior or cleared value.
- The multiply-accumulate is pure combinational logic from the inputs to the slot register: 32 multipliers plus an adder tree. There is no internal pipeline.

## Timing
- Reset asserted (`reset` = 0): `Answer` = 0 and `row_q` = 0 immediately, independent of `clk`.
- Reset is held while low. Input changes during reset are ignored.
- The first edge after `reset` rises performs a normal write using `row_q` = 0.
- Latency: inputs present at edge n appear in `Answer` slot `index_B` just after edge n. Throughput is 1 element per cycle.
- A full row of C takes 32 cycles (`index_B` = 0..31 with `index_A` held).
- Reset asserted mid-row discards all partial results.
- Row change and write on the same edge: the clear applies to all slots except `index_B`, which receives the new value.

## Configuration
- Macro `MM32_SATURATE_EN`.
  - Defined: the 69-bit exact sum S is clamped to the signed 32-bit range before being written. Values above 0x7FFFFFFF give 0x7FFFFFFF; values below 0x80000000 give 0x80000000.
  - Undefined: S[31:0] is written (wrap-around).
- All other behaviour is identical in both builds.

## Test plan
- Reset: drive `reset` = 0 with nonzero inputs and toggle `clk` → `Answer` = 0 throughout. Release, then one edge with A = B = all elements 1, `index_A` = 0, `index_B` = 0 → slot 0 = 32, other slots 0.
- Row sweep: A element k = k, B element k = 1, `index_A` = 0, `index_B` stepping 0..31 over 32 edges → every slot = 496.
- New row: after the sweep, set `index_A` = 1, `index_B` = 5, A = B = all 2 → slot 5 = 128, all other slots 0.
- Signed values: A all −3 (0xFFFFFFFD), B all 7 → slot = −672 (0xFFFFFD60).
- Overflow: A = B = all 0x7FFFFFFF.
  - Without macro → slot = 0x00000020.
  - With `MM32_SATURATE_EN` → slot = 0x7FFFFFFF.
- Async reset mid-row: after 10 writes, pull `reset` low between edges → `Answer` is 0 before the next edge, and `row_q` returns to 0.
